instr_encoder: RTL and testbench
================================

# instr_encoder

Streaming RISC-V RV32I instruction encoder. It does the inverse of the immediate generator: it takes decoded fields (format, opcode, registers, functs, 32-bit immediate) and packs them into a 32-bit instruction word. Each valid word is written sequentially into instruction memory through a write port with a stall handshake. It sits between the test/boot loader and instruction memory. It also checks immediate range and alignment, and rejects unencodable requests without writing.

## Interface
- `ADDR_W`, 10 — memory byte-address width.
- `BASE_ADDR`, 0 — byte address of the first write after reset or `clr`; must be a multiple of 4.
- `clk`  in  1  — system clock, rising edge.
- `rst_n`  in  1  — synchronous, active-low reset.
- `clr`  in  1  — synchronous abort/restart: drop any pending write, reload address, clear counters.
- `req_valid`  in  1  — request present.
- `req_ready`  out  1  — encoder can accept a request.
- `fmt`  in  3  — 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 illegal.
- `opcode`  in  7  — placed in bits [6:0] verbatim.
- `rd`, `rs1`, `rs2`  in  5 each — register fields.
- `funct3`  in  3; `funct7`  in  7 — function fields.
- `imm`  in  32 — immediate as the decoder would output it (sign-extended / pre-shifted).
- `mem_we`  out  1 — write strobe.
- `mem_addr`  out  ADDR_W — word-aligned byte address.
- `mem_wdata`  out  32 — encoded instruction.
- `mem_ready`  in  1 — memory accepts the write this cycle.
- `err`  out  1 — one-cycle pulse when a request is rejected.
- `err_code`  out  2 — 01 range, 10 misaligned, 11 illegal fmt; held until the next error or reset.
- `word_count`  out  16 — number of words written since reset/`clr`; saturates at 0xFFFF.
- `wrapped`  out  1 — sticky flag: the address wrapped past the top.

## Operation
- States: IDLE (`req_ready`=1), WRITE (`mem_we`=1, `req_ready`=0).
- IDLE + `req_valid`: accept. The word is encoded and checked in the same cycle and registered.
  - Check passes: go to WRITE.
  - Check fails: stay in IDLE, pulse `err` next cycle, update `err_code`. No write; address and count unchanged.
- WRITE: hold `mem_we`, `mem_addr`, `mem_wdata` stable until `mem_ready`=1.
  - That cycle: the write completes, `mem_addr` += 4, `word_count` += 1, and the next state is IDLE.
- Address wrap: a completed write at address 2^ADDR_W−4 sets the next address to 0 (modulo arithmetic) and sets `wrapped`.
- Encoding:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}; `imm` ignored.
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- Checks, in priority order (highest first):
  1. Illegal fmt → 11.
  2. Misaligned → 10:
     - B or J with imm[0]=1;
     - U with imm[11:0]≠0.
  3. Range → 01:
     - I/S: imm[31:11] not all equal;
     - B: imm[31:12] not all equal;
     - J: imm[31:20] not all equal.
  - R never errors.
- `clr` has priority over everything:
  - next cycle the state is IDLE, `mem_we`=0, address = BASE_ADDR, `word_count`=0, `wrapped`=0;
  - a request presented in the same cycle as `clr` is not accepted (`req_ready` is forced 0 while `clr`=1);
  - `err_code` is not cleared.
- Reset (`rst_n`=0) does the same as `clr` and also clears `err_code`.

## Timing
- Reset values:
  - `req_ready`=1 (after reset release), `mem_we`=0, `mem_addr`=BASE_ADDR, `mem_wdata`=0;
  - `err`=0, `err_code`=00, `word_count`=0, `wrapped`=0.
- While `rst_n`=0, `req_ready`=0.
- Latency: a request accepted on edge N gives `mem_we`=1 with valid data in cycle N+1.
- Throughput: one word per 2 cycles with `mem_ready` tied high. There is no back-to-back accept: `req_ready`=0 throughout WRITE.
- Error path: `err` is high for exactly cycle N+1. `req_ready` stays 1, so a new request is accepted in cycle N+1.
- `mem_wdata` and `mem_addr` may not change while `mem_we`=1 and `mem_ready`=0.
- Reset or `clr` during WRITE: the stalled write is dropped and `mem_we` is 0 on the next cycle.

## Test plan
- Reset, then `rst_n`=1 → `req_ready`=1, `mem_addr`=0, `word_count`=0, `err_code`=00.
- Five requests, each followed by one `mem_ready` cycle:
  - addi x5,x10,10 → 0x00A50293 @0;
  - sw x5,13(x3) → 0x0051A6A3 @4;
  - beq x1,x2,8 → 0x00208463 @8;
  - lui x10,0x12345000 → 0x12345537 @12;
  - jal x0,16 → 0x0100006F @16;
  - expect `word_count`=5.
- Hold `mem_ready`=0 for 3 cycles after addi → `mem_we` and data stable for all 4 cycles, `req_ready`=0, address advances only after `mem_ready`.
- Error requests, each gives an `err` pulse and no `mem_we`:
  - B imm=9 → `err_code` 10;
  - I imm=2048 → 01;
  - fmt=6 → 11;
  - J imm=−1048576 with imm[0]=0 → accepted, encodes imm[20]=1.
- ADDR_W=4: write 4 words → 4th at 12, next `mem_addr`=0, `wrapped`=1; then `clr` → `wrapped`=0, `word_count`=0.
- `clr` asserted during a stalled WRITE → next cycle `mem_we`=0, IDLE, `mem_addr`=BASE_ADDR, no count increment.

Source files
------------

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word and streams
// accepted words into instruction memory through a stallable write port.
module instr_encoder #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [15:0]       word_count,
    output logic              wrapped
);

    localparam logic [ADDR_W-1:0] L_BASE = ADDR_W'(BASE_ADDR);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_RANGE = 2'b01;
    localparam logic [1:0] ERR_ALIGN = 2'b10;
    localparam logic [1:0] ERR_FMT   = 2'b11;

    typedef enum logic {
        S_IDLE,
        S_WRITE
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_wdata;
    logic               r_err;
    logic [1:0]         r_errCode;
    logic [15:0]        r_count;
    logic               r_wrapped;

    logic [31:0]        w_word;
    logic [1:0]         w_code;
    logic               w_fits12;
    logic               w_fits13;
    logic               w_fits21;
    logic               w_accept;
    logic               w_done;

    // An immediate fits N signed bits when every bit above N-1 copies the sign bit.
    assign w_fits12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign w_fits13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign w_fits21 = (&imm[31:20]) | ~(|imm[31:20]);

    always_comb begin
        w_word = 32'h0;
        w_code = ERR_NONE;
        case (fmt)
            FMT_R: begin
                w_word = {funct7, rs2, rs1, funct3, rd, opcode};
            end
            FMT_I: begin
                w_word = {imm[11:0], rs1, funct3, rd, opcode};
                if (!w_fits12) w_code = ERR_RANGE;
            end
            FMT_S: begin
                w_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                if (!w_fits12) w_code = ERR_RANGE;
            end
            FMT_B: begin
                w_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                if (imm[0])         w_code = ERR_ALIGN;
                else if (!w_fits13) w_code = ERR_RANGE;
            end
            FMT_U: begin
                w_word = {imm[31:12], rd, opcode};
                if (imm[11:0] != 12'h0) w_code = ERR_ALIGN;
            end
            FMT_J: begin
                w_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                if (imm[0])         w_code = ERR_ALIGN;
                else if (!w_fits21) w_code = ERR_RANGE;
            end
            default: begin
                w_code = ERR_FMT;
            end
        endcase
    end

    assign req_ready = rst_n & ~clr & (r_state == S_IDLE);
    assign w_accept  = req_valid & req_ready;
    assign w_done    = (r_state == S_WRITE) & mem_ready & ~clr;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        if (clr) begin
            w_nextState = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_accept && (w_code == ERR_NONE)) w_nextState = S_WRITE;
                S_WRITE: if (mem_ready) w_nextState = S_IDLE;
                default: w_nextState = S_IDLE;
            endcase
        end
    end

    // Rejected requests only touch the error registers; address and count move on completion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr    <= L_BASE;
            r_wdata   <= 32'h0;
            r_err     <= 1'b0;
            r_errCode <= ERR_NONE;
            r_count   <= 16'h0;
            r_wrapped <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (clr) begin
                r_addr    <= L_BASE;
                r_count   <= 16'h0;
                r_wrapped <= 1'b0;
            end else begin
                if (w_accept) begin
                    if (w_code != ERR_NONE) begin
                        r_err     <= 1'b1;
                        r_errCode <= w_code;
                    end else begin
                        r_wdata <= w_word;
                    end
                end
                if (w_done) begin
                    r_addr <= r_addr + ADDR_W'(4);
                    if (&r_addr[ADDR_W-1:2]) r_wrapped <= 1'b1;
                    if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
                end
            end
        end
    end

    assign mem_we     = (r_state == S_WRITE);
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign err        = r_err;
    assign err_code   = r_errCode;
    assign word_count = r_count;
    assign wrapped    = r_wrapped;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: requests push expected writes/errors, a
// negedge monitor pops them when the encoder presents a write or an error pulse.
module tb_instr_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, clr, clrW, req_valid, mem_ready;
    logic [2:0]  fmt, funct3;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;

    logic        req_ready, mem_we, err, wrapped;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  err_code;
    logic [15:0] word_count;

    logic        req_readyW, mem_weW, errW, wrappedW;
    logic [3:0]  mem_addrW;
    logic [31:0] mem_wdataW;
    logic [1:0]  err_codeW;
    logic [15:0] word_countW;

    instr_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .req_valid(req_valid), .req_ready(req_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .funct7(funct7), .imm(imm), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .err(err), .err_code(err_code),
        .word_count(word_count), .wrapped(wrapped)
    );

    instr_encoder #(.ADDR_W(4), .BASE_ADDR(0)) dutW (
        .clk(clk), .rst_n(rst_n), .clr(clrW), .req_valid(req_valid), .req_ready(req_readyW),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .funct7(funct7), .imm(imm), .mem_we(mem_weW), .mem_addr(mem_addrW),
        .mem_wdata(mem_wdataW), .mem_ready(mem_ready), .err(errW), .err_code(err_codeW),
        .word_count(word_countW), .wrapped(wrappedW)
    );

    int nChecks = 0;
    int nPass   = 0;

    logic [41:0] wrQ[$];
    logic [1:0]  errQ[$];
    logic [9:0]  expAddr = '0;
    int          expCount = 0;
    logic [1:0]  expErrCode = 2'b00;
    logic        targetW = 1'b0;
    logic        randReady = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference model: range limits expressed as signed integer bounds.
    function automatic logic [33:0] refModel(input logic [2:0] f, input logic [6:0] op,
                                             input logic [4:0] d, input logic [4:0] s1,
                                             input logic [4:0] s2, input logic [2:0] f3,
                                             input logic [6:0] f7, input logic [31:0] im);
        int          simm;
        logic [1:0]  code;
        logic [31:0] w;
        simm = int'(signed'(im));
        code = 2'b00;
        w    = 32'h0;
        case (f)
            3'd0: w = {f7, s2, s1, f3, d, op};
            3'd1, 3'd2: begin
                if (simm < -2048 || simm > 2047) code = 2'b01;
                if (f == 3'd1) w = {im[11:0], s1, f3, d, op};
                else           w = {im[11:5], s2, s1, f3, im[4:0], op};
            end
            3'd3: begin
                if ((simm % 2) != 0) code = 2'b10;
                else if (simm < -4096 || simm > 4095) code = 2'b01;
                w = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
            end
            3'd4: begin
                if ((im % 4096) != 0) code = 2'b10;
                w = {im[31:12], d, op};
            end
            3'd5: begin
                if ((simm % 2) != 0) code = 2'b10;
                else if (simm < -1048576 || simm > 1048575) code = 2'b01;
                w = {im[20], im[10:1], im[11], im[19:12], d, op};
            end
            default: code = 2'b11;
        endcase
        return {code, w};
    endfunction

    task automatic applyStimulus(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                                 input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] im,
                                 input logic [1:0] eCode, input logic [31:0] eWord);
        int g = 0;
        while (!(targetW ? req_readyW : req_ready) && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 100) begin
            nChecks++;
            $display("[TB] FAIL req_ready_timeout: got 0 expected 1");
        end
        fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
        req_valid = 1'b1;
        if (!targetW) begin
            if (eCode != 2'b00) begin
                errQ.push_back(eCode);
                expErrCode = eCode;
            end else begin
                wrQ.push_back({expAddr, eWord});
                expAddr  = expAddr + 10'd4;
                expCount = expCount + 1;
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic modelReq(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                            input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] im);
        logic [33:0] r;
        r = refModel(f, op, d, s1, s2, f3, f7, im);
        applyStimulus(f, op, d, s1, s2, f3, f7, im, r[33:32], r[31:0]);
    endtask

    task automatic drain();
        int g = 0;
        while ((wrQ.size() != 0 || errQ.size() != 0) && g < 200) begin
            @(negedge clk);
            g++;
        end
        checkOutput("wrQ_drained", wrQ.size(), 0);
        checkOutput("errQ_drained", errQ.size(), 0);
        @(posedge clk); #1;
    endtask

    always @(posedge clk) begin
        #1;
        if (randReady) mem_ready = 1'($urandom_range(0, 1));
    end

    logic        prevStall = 1'b0;
    logic [9:0]  prevAddr;
    logic [31:0] prevData;
    logic [41:0] e;

    always @(negedge clk) begin
        if (rst_n && !clr) begin
            if (mem_we && prevStall) begin
                checkOutput("stall_addr_stable", mem_addr, prevAddr);
                checkOutput("stall_data_stable", mem_wdata, prevData);
            end
            if (mem_we && mem_ready) begin
                if (wrQ.size() == 0) begin
                    nChecks++;
                    $display("[TB] FAIL unexpected_write: got addr 0x%03h data 0x%08h expected none",
                             mem_addr, mem_wdata);
                end else begin
                    e = wrQ.pop_front();
                    checkOutput("write_addr", mem_addr, e[41:32]);
                    checkOutput("write_data", mem_wdata, e[31:0]);
                end
            end
            if (err) begin
                if (errQ.size() == 0) begin
                    nChecks++;
                    $display("[TB] FAIL unexpected_err: got code %0d expected none", err_code);
                end else begin
                    checkOutput("err_code", err_code, errQ.pop_front());
                end
            end
        end
        prevStall = rst_n && !clr && mem_we && !mem_ready;
        prevAddr  = mem_addr;
        prevData  = mem_wdata;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [31:0] r;
        logic [2:0]  f;
        rst_n = 1'b0; clr = 1'b0; clrW = 1'b1; req_valid = 1'b0; mem_ready = 1'b0;
        fmt = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("req_ready_in_reset", req_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_req_ready", req_ready, 1);
        checkOutput("rst_mem_we", mem_we, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_mem_wdata", mem_wdata, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_err_code", err_code, 0);
        checkOutput("rst_word_count", word_count, 0);
        checkOutput("rst_wrapped", wrapped, 0);
        @(posedge clk); #1;

        // Directed program from the reference listing
        mem_ready = 1'b1;
        applyStimulus(3'd1, 7'h13, 5'd5, 5'd10, 5'd0, 3'd0, 7'd0, 32'd10, 2'b00, 32'h00A50293);
        applyStimulus(3'd2, 7'h23, 5'd0, 5'd3, 5'd5, 3'd2, 7'd0, 32'd13, 2'b00, 32'h0051A6A3);
        applyStimulus(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, 2'b00, 32'h00208463);
        applyStimulus(3'd4, 7'h37, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 2'b00, 32'h12345537);
        applyStimulus(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16, 2'b00, 32'h0100006F);
        drain();
        checkOutput("count_after_five", word_count, 5);
        checkOutput("addr_after_five", mem_addr, 20);

        // Stalled write: three cycles without mem_ready
        mem_ready = 1'b0;
        applyStimulus(3'd1, 7'h13, 5'd5, 5'd10, 5'd0, 3'd0, 7'd0, 32'd10, 2'b00, 32'h00A50293);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("stall_we", mem_we, 1);
            checkOutput("stall_req_ready", req_ready, 0);
            checkOutput("stall_addr", mem_addr, 20);
            checkOutput("stall_data", mem_wdata, 32'h00A50293);
            @(posedge clk); #1;
            if (k == 2) mem_ready = 1'b1;
        end
        @(negedge clk);
        checkOutput("after_stall_addr", mem_addr, 24);
        checkOutput("after_stall_count", word_count, 6);
        checkOutput("after_stall_we", mem_we, 0);
        @(posedge clk); #1;

        // Rejected requests pulse err in the following cycle with no write
        applyStimulus(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd9, 2'b10, 32'h0);
        @(negedge clk);
        checkOutput("err_pulse_b", err, 1);
        checkOutput("err_no_we_b", mem_we, 0);
        checkOutput("err_req_ready_b", req_ready, 1);
        @(posedge clk); #1;
        applyStimulus(3'd1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd2048, 2'b01, 32'h0);
        @(negedge clk);
        checkOutput("err_pulse_i", err, 1);
        checkOutput("err_no_we_i", mem_we, 0);
        @(posedge clk); #1;
        applyStimulus(3'd6, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd0, 2'b11, 32'h0);
        @(negedge clk);
        checkOutput("err_pulse_fmt", err, 1);
        checkOutput("err_no_we_fmt", mem_we, 0);
        @(posedge clk); #1;
        applyStimulus(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF00000, 2'b00, 32'h8000006F);
        drain();
        checkOutput("err_code_held", err_code, 3);
        checkOutput("count_after_err", word_count, expCount);

        // Randomized traffic with random memory back-pressure
        randReady = 1'b1;
        for (int n = 0; n < 80; n++) begin
            r = $urandom;
            f = ($urandom_range(0, 7) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5));
            case ($urandom_range(0, 4))
                0: imm = $urandom;
                1: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
                2: imm = {{11{r[20]}}, r[20:0]};
                3: imm = {r[19:0], 12'h0};
                default: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            endcase
            modelReq(f, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                     3'($urandom), 7'($urandom), imm);
        end
        randReady = 1'b0;
        @(posedge clk); #2;
        mem_ready = 1'b1;
        drain();
        checkOutput("rand_count", word_count, expCount);
        checkOutput("rand_addr", mem_addr, expAddr);
        checkOutput("rand_err_code", err_code, expErrCode);

        // clr during a stalled write drops it
        mem_ready = 1'b0;
        modelReq(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'h0);
        @(negedge clk);
        checkOutput("clr_pre_we", mem_we, 1);
        @(posedge clk); #1;
        clr = 1'b1;
        @(negedge clk);
        checkOutput("clr_req_ready", req_ready, 0);
        @(posedge clk); #1;
        clr = 1'b0;
        wrQ.delete();
        expAddr  = '0;
        expCount = 0;
        @(negedge clk);
        checkOutput("clr_we", mem_we, 0);
        checkOutput("clr_req_ready_after", req_ready, 1);
        checkOutput("clr_addr", mem_addr, 0);
        checkOutput("clr_count", word_count, 0);
        checkOutput("clr_wrapped", wrapped, 0);
        checkOutput("clr_keeps_err_code", err_code, expErrCode);
        @(posedge clk); #1;
        mem_ready = 1'b1;
        modelReq(3'd1, 7'h13, 5'd7, 5'd8, 5'd0, 3'd0, 7'd0, 32'hFFFFF800);
        drain();
        checkOutput("post_clr_count", word_count, 1);
        checkOutput("post_clr_addr", mem_addr, 4);

        // Narrow instance: address wraps after four words
        clr = 1'b1;
        clrW = 1'b0;
        targetW = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            r = 32'(refModel(3'd1, 7'h13, 5'(k), 5'd1, 5'd0, 3'd0, 7'd0, 32'(k)));
            applyStimulus(3'd1, 7'h13, 5'(k), 5'd1, 5'd0, 3'd0, 7'd0, 32'(k), 2'b00, r);
            @(negedge clk);
            checkOutput("wrap_we", mem_weW, 1);
            checkOutput("wrap_addr", mem_addrW, 32'(4 * k));
            checkOutput("wrap_data", mem_wdataW, r);
            checkOutput("wrap_flag_before", wrappedW, 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        checkOutput("wrap_next_addr", mem_addrW, 0);
        checkOutput("wrap_flag", wrappedW, 1);
        checkOutput("wrap_count", word_countW, 4);
        @(posedge clk); #1;
        clrW = 1'b1;
        @(posedge clk); #1;
        clrW = 1'b0;
        @(negedge clk);
        checkOutput("wrap_clr_flag", wrappedW, 0);
        checkOutput("wrap_clr_count", word_countW, 0);
        checkOutput("wrap_clr_addr", mem_addrW, 0);
        @(posedge clk); #1;
        targetW = 1'b0;
        clr = 1'b0;

        // Reset also clears the sticky error code
        rst_n = 1'b0;
        @(posedge clk); #1;
        checkOutput("rst2_req_ready", req_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst2_err_code", err_code, 0);
        checkOutput("rst2_count", word_count, 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
